// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack: output end of the FP adder datapath.
// Takes the ALU-stage result, which is an aligned magnitude with a carry, a sign and a
// common exponent. It renormalizes with one shift per cycle and packs an IEEE-754 word.
//
// Optional feature macro: FP_NORM_ROUND_EN
//   defined   : guard bit and round-half-even (no sticky) at pack time
//   undefined : the bit dropped by the carry right shift is discarded (truncation)
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       ALU-stage result valid
//   in_ready       block can accept a new result (registered)
//   alignedResult  aligned magnitude, bit MANT_W is the hidden-bit position
//   alignedSign    result sign
//   carryOut       magnitude carry (bit MANT_W+1)
//   exponentOut    common exponent from the align stage
//   out_valid      Result valid (registered)
//   out_ready      consumer accepts Result
//   Result         packed {sign, exp, frac} (registered)
module fp_normalize_pack #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANT_W:0]           alignedResult,
    input  logic                      alignedSign,
    input  logic                      carryOut,
    input  logic [EXP_W-1:0]          exponentOut,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     Result
);

    localparam int unsigned MANT_WIDE = MANT_W + 2;
    localparam int unsigned EXP_WIDE  = EXP_W + 1;
    localparam int unsigned RES_W     = EXP_W + MANT_W + 1;
    localparam int unsigned EXP_MAX   = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [MANT_WIDE-1:0]   mant_q, mant_d;
    logic [EXP_WIDE-1:0]    exp_q, exp_d;
    logic                   sign_q, sign_d;
    logic [RES_W-1:0]       result_q, result_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
`ifdef FP_NORM_ROUND_EN
    logic                   guard_q, guard_d;
    logic [MANT_WIDE-1:0]   mant_rnd;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Result    = result_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FP_NORM_ROUND_EN
            guard_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef FP_NORM_ROUND_EN
            guard_q     <= guard_d;
`endif
        end
    end

    // Next-state and datapath: one normalization rule per NORM cycle, in priority order
    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef FP_NORM_ROUND_EN
        guard_d     = guard_q;
        mant_rnd    = mant_q + MANT_WIDE'(1);
`endif
        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    mant_d     = {carryOut, alignedResult};
                    exp_d      = {1'b0, exponentOut};
                    sign_d     = alignedSign;
`ifdef FP_NORM_ROUND_EN
                    guard_d    = 1'b0;
`endif
                    in_ready_d = 1'b0;
                    state_d    = NORM;
                end
            end
            NORM: begin
                if (mant_q[MANT_W+1]) begin
                    mant_d = mant_q >> 1;
                    exp_d  = exp_q + EXP_WIDE'(1);
`ifdef FP_NORM_ROUND_EN
                    guard_d = mant_q[0];
`endif
                end else if (mant_q == '0) begin
                    result_d    = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mant_q[MANT_W] && (exp_q >= EXP_WIDE'(EXP_MAX))) begin
                    result_d    = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mant_q[MANT_W] && (exp_q == '0)) begin
                    result_d    = {sign_q, {(RES_W-1){1'b0}}};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mant_q[MANT_W]) begin
`ifdef FP_NORM_ROUND_EN
                    if (guard_q && mant_q[0]) begin
                        if (mant_rnd[MANT_W+1]) begin
                            // Rounding carried out of the hidden bit: renormalize next cycle
                            mant_d  = mant_rnd;
                            guard_d = 1'b0;
                        end else begin
                            result_d    = {sign_q, exp_q[EXP_W-1:0], mant_rnd[MANT_W-1:0]};
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                    end else begin
                        result_d    = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-1:0]};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
`else
                    result_d    = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-1:0]};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`endif
                end else if (exp_q <= EXP_WIDE'(1)) begin
                    // No denormals: anything that cannot reach exp>=1 flushes to signed zero
                    result_d    = {sign_q, {(RES_W-1){1'b0}}};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
`ifdef FP_NORM_ROUND_EN
                    mant_d  = {mant_q[MANT_W:0], guard_q};
                    guard_d = 1'b0;
`else
                    mant_d  = {mant_q[MANT_W:0], 1'b0};
`endif
                    exp_d   = exp_q - EXP_WIDE'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Self-checking bench for fp_normalize_pack: scoreboard queue filled by the driver,
// drained by an independent output monitor; arithmetic reference model.
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] alignedResult;
    logic        alignedSign;
    logic        carryOut;
    logic [7:0]  exponentOut;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;

    fp_normalize_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alignedResult (alignedResult),
        .alignedSign   (alignedSign),
        .carryOut      (carryOut),
        .exponentOut   (exponentOut),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Result        (Result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          hs;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   hold5  = 1'b0;
    bit   prev_ov = 1'b0;
    int   hold_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value-level normalization of {carry, magnitude} * 2^exp
    function automatic void model(input logic c, input logic [23:0] a, input logic s,
                                  input logic [7:0] e, output logic [31:0] r, output int lat);
        longint m;
        int     ex;
        int     p;
        int     k;
        bit     g;
        m   = longint'({c, a});
        ex  = int'(e);
        g   = 1'b0;
        lat = 2;
        if (m == 0) begin
            r = 32'h0;
            return;
        end
        if (m >= (64'd1 << 24)) begin
            g   = m[0];
            m   = m >> 1;
            ex  = ex + 1;
            lat = lat + 1;
        end
        p = 0;
        for (int i = 23; i >= 0; i--) begin
            if (m[i] && p == 0) p = i;
        end
        if (m[0] && m < 2) p = 0;
        k = 23 - p;
        if (k > 0) begin
            if (ex - k < 1) begin
                r   = {s, 31'h0};
                lat = lat + ((ex > 1) ? ex - 1 : 0);
                return;
            end
            m   = m << k;
            ex  = ex - k;
            lat = lat + k;
        end
        if (ex >= 255) begin
            r = {s, 8'hFF, 23'h0};
            return;
        end
        if (ex == 0) begin
            r = {s, 31'h0};
            return;
        end
`ifdef FP_NORM_ROUND_EN
        if (g && m[0]) begin
            m = m + 1;
            if (m == (64'd1 << 24)) begin
                m   = m >> 1;
                ex  = ex + 1;
                lat = lat + 2;
                if (ex >= 255) begin
                    r = {s, 8'hFF, 23'h0};
                    return;
                end
            end
        end
`endif
        r = {s, 8'(ex), m[22:0]};
    endfunction

    task automatic send(input logic c, input logic [23:0] a, input logic s, input logic [7:0] e);
        int          t;
        exp_t        x;
        logic [31:0] r;
        int          lat;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 required 1 (cycle %0d)", cyc);
            return;
        end
        carryOut      = c;
        alignedResult = a;
        alignedSign   = s;
        exponentOut   = e;
        in_valid      = 1'b1;
        model(c, a, s, e, r, lat);
        x.res = r;
        x.lat = lat;
        x.hs  = cyc;
        sbq.push_back(x);
        @(negedge clk);
        in_valid      = 1'b0;
        carryOut      = 1'($urandom);
        alignedResult = 24'($urandom);
        alignedSign   = 1'($urandom);
        exponentOut   = 8'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending required 0", sbq.size());
        end
    endtask

    // Output monitor: latency on out_valid rise, Result every DONE cycle, random backpressure
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("in_ready_low_while_out_valid", 32'(in_ready), 32'h0);
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got Result %h required no output", Result);
                    out_ready = 1'b1;
                end else begin
                    if (!prev_ov) begin
                        chk("latency", 32'(cyc - sbq[0].hs), 32'(sbq[0].lat));
                        hold_left = hold5 ? 5 : int'($urandom_range(0, 3));
                    end
                    chk("Result", Result, sbq[0].res);
                    if (hold_left > 0) begin
                        out_ready = 1'b0;
                        hold_left--;
                    end else begin
                        out_ready = 1'b1;
                        void'(sbq.pop_front());
                    end
                end
            end else begin
                out_ready = 1'($urandom);
            end
            prev_ov = out_valid;
        end
    end

    logic [7:0] e_pick [6];

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        carryOut      = 1'b0;
        alignedResult = 24'h0;
        alignedSign   = 1'b0;
        exponentOut   = 8'h0;
        e_pick[0] = 8'h00; e_pick[1] = 8'h01; e_pick[2] = 8'h02;
        e_pick[3] = 8'h7F; e_pick[4] = 8'hFE; e_pick[5] = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_Result", Result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: first output is held 5 cycles by the consumer
        hold5 = 1'b1;
        send(1'b0, 24'h800000, 1'b0, 8'h7F);
        drain();
        hold5 = 1'b0;
        send(1'b1, 24'h000000, 1'b0, 8'h7F);
        send(1'b0, 24'h200000, 1'b1, 8'h7F);
        send(1'b0, 24'h000000, 1'b1, 8'h7F);
        send(1'b0, 24'h000001, 1'b1, 8'h05);
        send(1'b1, 24'h000003, 1'b0, 8'h7F);
        send(1'b1, 24'h000003, 1'b0, 8'hFE);
        send(1'b1, 24'hFFFFFF, 1'b0, 8'h7F);
        send(1'b1, 24'hFFFFFF, 1'b1, 8'hFD);
        send(1'b0, 24'h800000, 1'b0, 8'h00);
        send(1'b0, 24'h800000, 1'b1, 8'hFF);
        send(1'b0, 24'h000001, 1'b0, 8'h7F);
        send(1'b0, 24'h400000, 1'b0, 8'h01);
        send(1'b0, 24'h400000, 1'b1, 8'h02);
        drain();

        // Randomized
        for (int n = 0; n < 300; n++) begin
            logic        c;
            logic [23:0] a;
            logic [7:0]  e;
            c = ($urandom_range(0, 3) == 0);
            a = 24'($urandom >> $urandom_range(8, 31));
            if ($urandom_range(0, 7) == 0) a = 24'hFFFFFF;
            e = ($urandom_range(0, 2) == 0) ? e_pick[$urandom_range(0, 5)] : 8'($urandom);
            send(c, a, 1'($urandom), e);
        end
        drain();

        // Reset in the middle of a long normalization
        send(1'b0, 24'h000001, 1'b0, 8'h7F);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'h0);
        chk("midreset_Result", Result, 32'h0);
        chk("midreset_in_ready", 32'(in_ready), 32'h1);
        sbq.delete();
        prev_ov = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 24'h800000, 1'b1, 8'h80);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
